// File: rtl/crc12_pkg.sv
// Shared CRC-12 definitions for the ROIC link transmit and receive sides.
// Generator x^12+x^10+x^7+x^4+x^3+x^2+x+1, 12 data bits per step, D[11] first.
package crc12_pkg;

    localparam int          CRC12_W    = 12;
    // Low twelve generator coefficients (x^10,x^7,x^4,x^3,x^2,x^1,x^0); x^12 is implicit.
    localparam logic [11:0] CRC12_POLY = 12'h49F;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } chk_state_e;

    // One CRC step over a full 12-bit word, MSB shifted in first.
    function automatic logic [CRC12_W-1:0] nextCRC12_D12(
        input logic [CRC12_W-1:0] data,
        input logic [CRC12_W-1:0] crc
    );
        logic [CRC12_W-1:0] c;
        logic               fb;
        c = crc;
        for (int i = CRC12_W - 1; i >= 0; i--) begin
            fb = c[CRC12_W-1] ^ data[i];
            c  = {c[CRC12_W-2:0], 1'b0};
            if (fb) begin
                c = c ^ CRC12_POLY;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc12_frame_checker.sv
// Receive-side CRC-12 frame checker: strips the trailing CRC word, forwards the
// payload with m_last moved onto the final payload word, and reports per-frame
// CRC and length status.
// Optional feature macro: CRC12_CHK_ERR_CNT_EN adds the crc_err_cnt output.
module crc12_frame_checker
    import crc12_pkg::*;
#(
    parameter int                 MAX_LEN  = 256,
    parameter logic [CRC12_W-1:0] CRC_INIT = 12'h000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [CRC12_W-1:0]            s_data,
    input  logic                          s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [CRC12_W-1:0]            m_data,
    output logic                          m_last,
    output logic                          status_valid,
    output logic                          crc_ok,
    output logic                          len_err,
`ifdef CRC12_CHK_ERR_CNT_EN
    output logic [15:0]                   crc_err_cnt,
`endif
    output logic [$clog2(MAX_LEN+2)-1:0]  frame_len
);

    localparam int               LEN_W   = $clog2(MAX_LEN + 2);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);

    chk_state_e           state_q;
    logic [CRC12_W-1:0]   hold_q;
    logic [CRC12_W-1:0]   crc_q;
    logic [LEN_W-1:0]     count_q;

    logic                 accept;
    logic                 frame_end;
    logic                 frame_good;

    // Input may advance whenever the output register is empty or draining.
    assign s_ready    = !m_valid || m_ready;
    assign accept     = s_valid && s_ready;
    assign frame_end  = accept && s_last;
    // A runt frame never matches, whatever its CRC word says.
    assign frame_good = (state_q == HOLD) && (s_data == crc_q);

    // Frame state: holds one payload word back so m_last can land on it once the CRC word shows up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            crc_q   <= CRC_INIT;
            count_q <= '0;
        end else if (accept) begin
            if (state_q == IDLE) begin
                if (!s_last) begin
                    hold_q  <= s_data;
                    crc_q   <= nextCRC12_D12(s_data, CRC_INIT);
                    count_q <= LEN_W'(1);
                    state_q <= HOLD;
                end
            end else begin
                if (!s_last) begin
                    hold_q <= s_data;
                    crc_q  <= nextCRC12_D12(s_data, crc_q);
                    if (count_q != LEN_SAT) begin
                        count_q <= count_q + LEN_W'(1);
                    end
                end else begin
                    crc_q   <= CRC_INIT;
                    count_q <= '0;
                    state_q <= IDLE;
                end
            end
        end
    end

    // Output register: loads the held word whenever a following word pushes it out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (accept && (state_q == HOLD)) begin
            m_valid <= 1'b1;
            m_data  <= hold_q;
            m_last  <= s_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Status pulse: one cycle per CRC word, fields held afterwards until the next frame ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_valid <= 1'b0;
            crc_ok       <= 1'b0;
            len_err      <= 1'b0;
            frame_len    <= '0;
        end else begin
            status_valid <= frame_end;
            if (frame_end) begin
                crc_ok <= frame_good;
                if (state_q == IDLE) begin
                    len_err   <= 1'b1;
                    frame_len <= '0;
                end else begin
                    len_err   <= (count_q > LEN_MAX);
                    frame_len <= count_q;
                end
            end
        end
    end

`ifdef CRC12_CHK_ERR_CNT_EN
    // Saturating count of frames that failed the CRC check, runts included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_err_cnt <= '0;
        end else if (frame_end && !frame_good && (crc_err_cnt != 16'hFFFF)) begin
            crc_err_cnt <= crc_err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_crc12_frame_checker.sv
// Self-checking bench for crc12_frame_checker (define CRC12_CHK_ERR_CNT_EN to cover the error counter).
module tb_crc12_frame_checker;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [11:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [11:0] m_data;
    logic        m_last;
    logic        status_valid;
    logic        crc_ok;
    logic        len_err;
    logic [8:0]  frame_len;
`ifdef CRC12_CHK_ERR_CNT_EN
    logic [15:0] crc_err_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic ok;
        logic lenErr;
        int   len;
        logic hasPay;
    } stat_t;

    typedef struct {
        int          n;
        logic [11:0] w0;
        logic [11:0] w1;
        logic [11:0] crcw;
        logic        expOk;
        logic        expLenErr;
        int          expLen;
    } vec_t;

    logic [11:0] frameQ[$];
    logic [11:0] expDataQ[$];
    logic        expLastQ[$];
    stat_t       expStatQ[$];
    int          expErrCnt = 0;
    int          readyMode = 0;

    crc12_frame_checker #(
        .MAX_LEN  (256),
        .CRC_INIT (12'h000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .status_valid (status_valid),
        .crc_ok       (crc_ok),
        .len_err      (len_err),
`ifdef CRC12_CHK_ERR_CNT_EN
        .crc_err_cnt  (crc_err_cnt),
`endif
        .frame_len    (frame_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference CRC: remainder of ((crc ^ word) * x^12) mod G, done as mod-2 long division per word.
    function automatic logic [11:0] modelCrc();
        logic [23:0] gen;
        logic [23:0] r;
        logic [11:0] rem;
        gen = 24'h00149F;
        rem = 12'h000;
        foreach (frameQ[k]) begin
            r = {rem ^ frameQ[k], 12'h000};
            for (int b = 23; b >= 12; b--) begin
                if (r[b]) r = r ^ (gen << (b - 12));
            end
            rem = r[11:0];
        end
        return rem;
    endfunction

    // Present one word and hold it until the DUT takes it (bounded).
    task automatic applyStimulus(input logic [11:0] d, input logic l);
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        do begin
            @(negedge clk);
            guard++;
        end while (!s_ready && guard < 2000);
        if (!s_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: s_ready stuck at 0, expected 1");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    // Queue the expected output for the frame in frameQ, then send it followed by its CRC word.
    task automatic runFrame(input logic [11:0] crcw, input logic eOk, input logic eLen, input int eN);
        stat_t st;
        foreach (frameQ[k]) begin
            expDataQ.push_back(frameQ[k]);
            expLastQ.push_back(k == frameQ.size() - 1);
        end
        st.ok     = eOk;
        st.lenErr = eLen;
        st.len    = eN;
        st.hasPay = (frameQ.size() > 0);
        expStatQ.push_back(st);
        foreach (frameQ[k]) applyStimulus(frameQ[k], 1'b0);
        applyStimulus(crcw, 1'b1);
    endtask

    // Wait for every queued expectation to be observed (bounded).
    task automatic drain();
        int guard;
        guard = 0;
        while ((expDataQ.size() != 0 || expStatQ.size() != 0) && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        #1;
        if (expDataQ.size() != 0 || expStatQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout: %0d words and %0d status left, expected 0",
                     expDataQ.size(), expStatQ.size());
            expDataQ.delete();
            expLastQ.delete();
            expStatQ.delete();
        end
    endtask

    // Downstream backpressure pattern, changed just after each rising edge.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       m_ready = 1'b1;
                1:       m_ready = !m_ready;
                2:       m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard: checks every output handshake, every status pulse, and stall stability.
    logic        prevStall = 1'b0;
    logic [11:0] prevData  = '0;
    logic        prevLast  = 1'b0;
    always @(negedge clk) begin
        stat_t st;
        if (rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_valid", m_valid, 1);
                checkOutput("stall_data", m_data, prevData);
                checkOutput("stall_last", m_last, prevLast);
            end
            if (status_valid) begin
                if (expStatQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_status: got status_valid=1, expected 0");
                end else begin
                    st = expStatQ.pop_front();
                    checkOutput("crc_ok", crc_ok, st.ok);
                    checkOutput("len_err", len_err, st.lenErr);
                    checkOutput("frame_len", frame_len, st.len);
                    if (st.hasPay) checkOutput("status_with_last", m_valid && m_last, 1);
`ifdef CRC12_CHK_ERR_CNT_EN
                    if (!st.ok) expErrCnt++;
                    checkOutput("crc_err_cnt", crc_err_cnt, expErrCnt);
`endif
                end
            end
            if (m_valid && m_ready) begin
                if (expDataQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_word: got 0x%0h, expected no output", m_data);
                end else begin
                    checkOutput("m_data", m_data, expDataQ.pop_front());
                    checkOutput("m_last", m_last, expLastQ.pop_front());
                end
            end
            prevStall = m_valid && !m_ready;
            prevData  = m_data;
            prevLast  = m_last;
        end
    end

    // Outputs that must read as reset values.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_s_ready"}, s_ready, 1);
        checkOutput({tag, "_m_valid"}, m_valid, 0);
        checkOutput({tag, "_m_data"}, m_data, 0);
        checkOutput({tag, "_m_last"}, m_last, 0);
        checkOutput({tag, "_status_valid"}, status_valid, 0);
        checkOutput({tag, "_crc_ok"}, crc_ok, 0);
        checkOutput({tag, "_len_err"}, len_err, 0);
        checkOutput({tag, "_frame_len"}, frame_len, 0);
`ifdef CRC12_CHK_ERR_CNT_EN
        checkOutput({tag, "_crc_err_cnt"}, crc_err_cnt, 0);
`endif
    endtask

    vec_t vecs[7];

    initial begin
        logic [11:0] good;
        logic [11:0] crcw;
        int          n;

        vecs[0] = '{n: 1, w0: 12'h001, w1: 12'h000, crcw: 12'h49F, expOk: 1, expLenErr: 0, expLen: 1};
        vecs[1] = '{n: 1, w0: 12'h001, w1: 12'h000, crcw: 12'h49E, expOk: 0, expLenErr: 0, expLen: 1};
        vecs[2] = '{n: 0, w0: 12'h000, w1: 12'h000, crcw: 12'h123, expOk: 0, expLenErr: 1, expLen: 0};
        vecs[3] = '{n: 2, w0: 12'h000, w1: 12'h000, crcw: 12'h000, expOk: 1, expLenErr: 0, expLen: 2};
        vecs[4] = '{n: 1, w0: 12'h002, w1: 12'h000, crcw: 12'h93E, expOk: 1, expLenErr: 0, expLen: 1};
        vecs[5] = '{n: 0, w0: 12'h000, w1: 12'h000, crcw: 12'h000, expOk: 0, expLenErr: 1, expLen: 0};
        vecs[6] = '{n: 1, w0: 12'h000, w1: 12'h000, crcw: 12'h001, expOk: 0, expLenErr: 0, expLen: 1};

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table vectors sent back to back under 1010 backpressure.
        readyMode = 1;
        foreach (vecs[i]) begin
            frameQ.delete();
            if (vecs[i].n > 0) frameQ.push_back(vecs[i].w0);
            if (vecs[i].n > 1) frameQ.push_back(vecs[i].w1);
            runFrame(vecs[i].crcw, vecs[i].expOk, vecs[i].expLenErr, vecs[i].expLen);
        end
        drain();

        // Length boundaries: exactly MAX_LEN, one over, two over (count saturates).
        readyMode = 0;
        for (int len = 256; len <= 258; len++) begin
            frameQ.delete();
            for (int k = 0; k < len; k++) frameQ.push_back(12'h000);
            runFrame(12'h000, 1'b1, (len > 256), (len > 257) ? 257 : len);
        end
        drain();

        // Randomized frames against the long-division model, random backpressure and gaps.
        readyMode = 2;
        for (int f = 0; f < 24; f++) begin
            frameQ.delete();
            n = $urandom_range(0, 9);
            for (int k = 0; k < n; k++) frameQ.push_back(12'($urandom));
            good = modelCrc();
            crcw = good;
            if ($urandom_range(0, 3) == 0) crcw = good ^ 12'($urandom_range(1, 4095));
            runFrame(crcw, (n > 0) && (crcw == good), (n == 0), n);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        // Reset mid-frame with a word sitting in the output register.
        readyMode = 3;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(12'h0AA, 1'b0);
        applyStimulus(12'h055, 1'b0);
        checkOutput("pre_reset_m_valid", m_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        expErrCnt = 0;
        checkResetValues("midreset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        readyMode = 0;
        @(posedge clk);
        #1;
        frameQ.delete();
        frameQ.push_back(12'h000);
        frameQ.push_back(12'h000);
        runFrame(12'h000, 1'b1, 1'b0, 2);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #3000000;
        failures++;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
